// File: rtl/burst_gate_multi.sv
// Multi-channel DAC burst gate: trigger-armed, repeating bursts of L samples every max(P,L) cycles.
// Outside bursts every lane carries the latched idle code; the output is one register deep.
module burst_gate_multi #(
  parameter int DATA_WIDTH = 14,
  parameter int CHANNELS   = 2,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [CHANNELS*DATA_WIDTH-1:0] dac_data,
  input  logic                           trigger_in,
  input  logic                           cfg_enable,
  input  logic [CNT_WIDTH-1:0]           cfg_burst_len,
  input  logic [CNT_WIDTH-1:0]           cfg_period,
  input  logic [CNT_WIDTH-1:0]           cfg_num_bursts,
  input  logic signed [DATA_WIDTH-1:0]   cfg_idle_value,
  output logic [CHANNELS*DATA_WIDTH-1:0] dac_out,
  output logic                           burst_active,
  output logic                           burst_done,
  output logic [CNT_WIDTH-1:0]           burst_count
);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_GAP} state_t;

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  state_t                        r_state;
  logic [CNT_WIDTH-1:0]          r_off;
  logic [CNT_WIDTH-1:0]          r_bidx;
  logic [CNT_WIDTH-1:0]          r_len;
  logic [CNT_WIDTH-1:0]          r_pe;
  logic [CNT_WIDTH-1:0]          r_num;
  logic signed [DATA_WIDTH-1:0]  r_idle;
  logic                          r_trig_d;
  logic                          r_done_p0;
  logic                          r_inc_p0;

  logic                 w_idle_st;
  logic                 w_start;
  logic                 w_cont;
  logic                 w_burst_pass;
  logic [CNT_WIDTH-1:0] w_cfg_pe;
  logic [CNT_WIDTH-1:0] w_len;
  logic [CNT_WIDTH-1:0] w_pe;
  logic [CNT_WIDTH-1:0] w_num;
  logic [CNT_WIDTH-1:0] w_off;
  logic [CNT_WIDTH-1:0] w_bidx;
  logic                 w_last_samp;
  logic                 w_last_burst;

  function automatic logic [CHANNELS*DATA_WIDTH-1:0] fn_replicate(
    input logic [DATA_WIDTH-1:0] v
  );
    return {CHANNELS{v}};
  endfunction

  assign w_idle_st    = (r_state == S_IDLE);
  assign w_start      = w_idle_st && cfg_enable && trigger_in && !r_trig_d && (cfg_burst_len != '0);
  assign w_cont       = w_idle_st && cfg_enable && (cfg_burst_len == '0);
  assign w_burst_pass = w_start || (r_state == S_ACTIVE);
  assign w_cfg_pe     = (cfg_period > cfg_burst_len) ? cfg_period : cfg_burst_len;

  // The start cycle already passes sample 0, so it decides from live config, not shadows.
  assign w_len        = w_idle_st ? cfg_burst_len  : r_len;
  assign w_pe         = w_idle_st ? w_cfg_pe       : r_pe;
  assign w_num        = w_idle_st ? cfg_num_bursts : r_num;
  assign w_off        = w_idle_st ? '0             : r_off;
  assign w_bidx       = w_idle_st ? '0             : r_bidx;
  assign w_last_samp  = (w_off == w_len - ONE);
  assign w_last_burst = (w_num != '0) && (w_bidx == w_num - ONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_off        <= '0;
      r_bidx       <= '0;
      r_len        <= '0;
      r_pe         <= '0;
      r_num        <= '0;
      r_idle       <= '0;
      r_trig_d     <= 1'b1;
      r_done_p0    <= 1'b0;
      r_inc_p0     <= 1'b0;
      dac_out      <= '0;
      burst_active <= 1'b0;
      burst_done   <= 1'b0;
      burst_count  <= '0;
    end else begin
      r_trig_d <= trigger_in;
      if (!cfg_enable) begin
        r_state      <= S_IDLE;
        r_off        <= '0;
        r_bidx       <= '0;
        r_idle       <= cfg_idle_value;
        r_done_p0    <= 1'b0;
        r_inc_p0     <= 1'b0;
        dac_out      <= fn_replicate(cfg_idle_value);
        burst_active <= 1'b0;
        burst_done   <= 1'b0;
      end else begin
        // Stage p0 -> output: completion flags lag the last passed sample by one cycle.
        burst_done <= r_done_p0;
        r_done_p0  <= 1'b0;
        r_inc_p0   <= 1'b0;
        if (w_start)
          burst_count <= '0;
        else if (r_inc_p0)
          burst_count <= burst_count + ONE;

        if (w_start) begin
          r_len  <= cfg_burst_len;
          r_pe   <= w_cfg_pe;
          r_num  <= cfg_num_bursts;
          r_idle <= cfg_idle_value;
        end

        if (w_cont || w_burst_pass) begin
          dac_out      <= dac_data;
          burst_active <= 1'b1;
        end else begin
          dac_out      <= fn_replicate(r_idle);
          burst_active <= 1'b0;
        end

        // r_off is the cycle offset inside the current period; samples occupy offsets 0..L-1.
        if (w_burst_pass) begin
          if (w_last_samp) begin
            r_inc_p0 <= 1'b1;
            if (w_last_burst) begin
              r_state   <= S_IDLE;
              r_off     <= '0;
              r_bidx    <= '0;
              r_done_p0 <= 1'b1;
            end else if (w_pe == w_len) begin
              r_state <= S_ACTIVE;
              r_off   <= '0;
              r_bidx  <= w_bidx + ONE;
            end else begin
              r_state <= S_GAP;
              r_off   <= w_off + ONE;
              r_bidx  <= w_bidx + ONE;
            end
          end else begin
            r_state <= S_ACTIVE;
            r_off   <= w_off + ONE;
            r_bidx  <= w_bidx;
          end
        end else if (r_state == S_GAP) begin
          if (r_off == r_pe - ONE) begin
            r_state <= S_ACTIVE;
            r_off   <= '0;
          end else begin
            r_off <= r_off + ONE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_burst_gate_multi.sv
// Directed bench for burst_gate_multi with four lanes, each carrying its own ramp.
module tb_burst_gate_multi;

  localparam int DW = 14;
  localparam int CH = 4;
  localparam int CW = 32;

  logic                clk;
  logic                reset;
  logic [CH*DW-1:0]    dac_data;
  logic                trigger_in;
  logic                cfg_enable;
  logic [CW-1:0]       cfg_burst_len;
  logic [CW-1:0]       cfg_period;
  logic [CW-1:0]       cfg_num_bursts;
  logic signed [DW-1:0] cfg_idle_value;
  logic [CH*DW-1:0]    dac_out;
  logic                burst_active;
  logic                burst_done;
  logic [CW-1:0]       burst_count;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int t0    = 0;

  burst_gate_multi #(.DATA_WIDTH(DW), .CHANNELS(CH), .CNT_WIDTH(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .dac_data      (dac_data),
    .trigger_in    (trigger_in),
    .cfg_enable    (cfg_enable),
    .cfg_burst_len (cfg_burst_len),
    .cfg_period    (cfg_period),
    .cfg_num_bursts(cfg_num_bursts),
    .cfg_idle_value(cfg_idle_value),
    .dac_out       (dac_out),
    .burst_active  (burst_active),
    .burst_done    (burst_done),
    .burst_count   (burst_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lane k of cycle n: distinct ramp per lane so any lane skew or swap shows up.
  function automatic logic [CH*DW-1:0] mk_data(input int n);
    logic [CH*DW-1:0] v;
    for (int k = 0; k < CH; k++)
      v[k*DW +: DW] = DW'(n * 7 + k * 1237 + 5);
    return v;
  endfunction

  function automatic logic [CH*DW-1:0] rep(input logic [DW-1:0] v);
    return {CH{v}};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Advance one clock; outputs are then checked and inputs for the new cycle driven.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    dac_data = mk_data(cyc);
  endtask

  task automatic start_burst();
    trigger_in = 1'b0;
    tick();
    trigger_in = 1'b1;
    t0 = cyc;
  endtask

  // Expected outputs k cycles after a start at t0, derived from the burst timing formulas.
  task automatic expect_cycle(input int k, input int L, input int P, input int N,
                              input logic [DW-1:0] idle);
    int  pe;
    int  cnt;
    bit  pass;
    bit  done;
    pe   = (P > L) ? P : L;
    cnt  = 0;
    pass = 0;
    for (int b = 0; (N == 0 || b < N) && b * pe <= k; b++) begin
      if (k - 1 >= b * pe && k - 1 <= b * pe + L - 1) pass = 1;
      if (b * pe + L + 1 <= k) cnt++;
    end
    done = (N != 0) && (k == (N - 1) * pe + L + 1);
    check_eq($sformatf("out_k%0d", k), 64'(dac_out), 64'(pass ? mk_data(t0 + k - 1) : rep(idle)));
    check_eq($sformatf("act_k%0d", k), 64'(burst_active), 64'(pass));
    check_eq($sformatf("done_k%0d", k), 64'(burst_done), 64'(done));
    check_eq($sformatf("cnt_k%0d", k), 64'(burst_count), 64'(cnt));
  endtask

  initial begin
    reset          = 1'b1;
    trigger_in     = 1'b1;
    cfg_enable     = 1'b1;
    cfg_burst_len  = 4;
    cfg_period     = 10;
    cfg_num_bursts = 1;
    cfg_idle_value = 14'h2000;
    dac_data       = mk_data(0);

    // Reset with trigger held high and data ramping
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("rst_out", 64'(dac_out), 64'd0);
      check_eq("rst_act", 64'(burst_active), 64'd0);
    end
    check_eq("rst_cnt", 64'(burst_count), 64'd0);
    check_eq("rst_done", 64'(burst_done), 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("postrst_out", 64'(dac_out), 64'd0);
      check_eq("postrst_act", 64'(burst_active), 64'd0);
    end

    // Single burst L=4 P=10 N=1
    start_burst();
    for (int k = 1; k <= 8; k++) begin
      tick();
      expect_cycle(k, 4, 10, 1, 14'h2000);
    end

    // Repeat with gap L=3 P=8 N=3, extra edge at t+5 ignored
    cfg_burst_len  = 3;
    cfg_period     = 8;
    cfg_num_bursts = 3;
    cfg_idle_value = 14'h1555;
    start_burst();
    for (int k = 1; k <= 24; k++) begin
      tick();
      expect_cycle(k, 3, 8, 3, 14'h1555);
      if (k == 1) trigger_in = 1'b0;
      if (k == 5) trigger_in = 1'b1;
    end

    // Back-to-back, infinite: L=5 P=2 N=0, enable dropped at t+23
    cfg_burst_len  = 5;
    cfg_period     = 2;
    cfg_num_bursts = 0;
    cfg_idle_value = 14'h0ABC;
    start_burst();
    for (int k = 1; k <= 23; k++) begin
      tick();
      expect_cycle(k, 5, 2, 0, 14'h0ABC);
    end
    cfg_enable = 1'b0;
    for (int k = 24; k <= 25; k++) begin
      tick();
      check_eq("dis_out", 64'(dac_out), 64'(rep(14'h0ABC)));
      check_eq("dis_act", 64'(burst_active), 64'd0);
      check_eq("dis_done", 64'(burst_done), 64'd0);
      check_eq("dis_cnt", 64'(burst_count), 64'd4);
    end

    // Continuous pass-through, trigger toggling
    cfg_enable    = 1'b1;
    cfg_burst_len = 0;
    trigger_in    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("cont_out", 64'(dac_out), 64'(mk_data(cyc - 1)));
      check_eq("cont_act", 64'(burst_active), 64'd1);
      trigger_in = ~trigger_in;
    end
    cfg_burst_len = 4;
    trigger_in    = 1'b0;
    tick();
    check_eq("leave_cont_out", 64'(dac_out), 64'(rep(14'h0ABC)));
    check_eq("leave_cont_act", 64'(burst_active), 64'd0);

    // Config latched at start: L changed to 9 mid-burst
    cfg_period     = 6;
    cfg_num_bursts = 1;
    cfg_idle_value = 14'h3FFF;
    trigger_in     = 1'b1;
    t0             = cyc;
    for (int k = 1; k <= 8; k++) begin
      tick();
      expect_cycle(k, 4, 6, 1, 14'h3FFF);
      if (k == 2) cfg_burst_len = 9;
    end

    // Reset asserted mid-burst
    cfg_burst_len  = 4;
    cfg_period     = 10;
    start_burst();
    tick();
    expect_cycle(1, 4, 10, 1, 14'h3FFF);
    reset = 1'b1;
    tick();
    check_eq("midrst_out", 64'(dac_out), 64'd0);
    check_eq("midrst_act", 64'(burst_active), 64'd0);
    check_eq("midrst_cnt", 64'(burst_count), 64'd0);
    check_eq("midrst_done", 64'(burst_done), 64'd0);
    reset = 1'b0;
    tick();

    // Multi-lane short burst L=2 N=1
    cfg_burst_len  = 2;
    cfg_period     = 2;
    cfg_num_bursts = 1;
    cfg_idle_value = 14'h2AAA;
    start_burst();
    for (int k = 1; k <= 5; k++) begin
      tick();
      expect_cycle(k, 2, 2, 1, 14'h2AAA);
    end

    // One-sample bursts back to back: L=1 P=1 N=3
    cfg_burst_len  = 1;
    cfg_period     = 1;
    cfg_num_bursts = 3;
    cfg_idle_value = 14'h0001;
    start_burst();
    for (int k = 1; k <= 6; k++) begin
      tick();
      expect_cycle(k, 1, 1, 3, 14'h0001);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/burst_gate_multi.md
Name: burst_gate_multi

Overview:
Parametrised multi-channel DAC burst gate, placed between the waveform generator and the DAC output stage. On a trigger edge it passes a programmable number of samples per channel. It repeats that burst at a programmable period for a programmable number of repetitions, and drives a programmable idle code at all other times. It supersedes the single-channel free-running burst counter and adds trigger arming, repetition, idle level and status outputs.

Parameters:
DATA_WIDTH, 14, bits per DAC sample
CHANNELS, 2, number of DAC channels packed on the data buses
CNT_WIDTH, 32, width of length/period/count configuration and internal counters

Ports:
clk  in  1  system clock; sole clock domain
reset  in  1  synchronous, active-high reset
dac_data  in  CHANNELS*DATA_WIDTH  input samples; channel k at bits [k*DATA_WIDTH +: DATA_WIDTH]
trigger_in  in  1  burst start request; rising edge detected internally
cfg_enable  in  1  gate enable; low forces idle output
cfg_burst_len  in  CNT_WIDTH  samples per burst (L); 0 = continuous pass-through
cfg_period  in  CNT_WIDTH  cycles between burst starts (P)
cfg_num_bursts  in  CNT_WIDTH  bursts per trigger (N); 0 = repeat until disabled
cfg_idle_value  in  DATA_WIDTH  code driven on every channel outside bursts (two's complement)
dac_out  out  CHANNELS*DATA_WIDTH  registered gated samples
burst_active  out  1  high when dac_out carries passed data
burst_done  out  1  one-cycle pulse when the N-th burst completes
burst_count  out  CNT_WIDTH  bursts completed since last start; wraps modulo 2^CNT_WIDTH

Behaviour:
- Reset values:
  - dac_out=0 (not the idle value).
  - burst_active=0, burst_done=0, burst_count=0.
  - State IDLE, all counters 0.
  - The trigger edge register resets to 1, so a trigger held high through reset does not start a burst.
- Edge detect: start at cycle t when trigger_in=1 at t, trigger_in=0 at t-1, cfg_enable=1, state IDLE, cfg_burst_len!=0. Edges in any other state are ignored.
- On start, L, P, N and the idle value are latched into shadow registers. Config changes take effect only at the next start.
- The period actually used is P' = max(P, L). P<=L gives back-to-back bursts with no idle gap.
- States:
  - IDLE: output the idle code. On a start go to ACTIVE.
  - ACTIVE: pass samples and count them. After the L-th sample, go to GAP, or go straight to ACTIVE of the next burst if P'=L and bursts remain. After the last burst, go to IDLE.
  - GAP: output the idle code until P' cycles have elapsed since the current burst start, then go to ACTIVE.
- Timing, 1-cycle latency:
  - Burst b (b=0..N-1) passes dac_data from cycles t+b*P' .. t+b*P'+L-1.
  - These samples appear on dac_out one cycle later; burst_active is high exactly for those dac_out cycles.
  - All other dac_out cycles carry the latched idle value replicated on every channel.
- burst_count increments in the cycle after each burst's final sample is output. It is cleared to 0 on every start.
- burst_done pulses at t+(N-1)*P'+L+1, the first idle dac_out cycle after the last burst. It never pulses when N=0.
- Continuous mode: while in IDLE with cfg_burst_len=0 and cfg_enable=1:
  - dac_out <= dac_data every cycle; burst_active=1; trigger ignored.
  - Leaving continuous mode (L becomes nonzero or enable drops) returns the output to idle the next cycle.
- cfg_enable=0 in any state:
  - Next cycle: state IDLE, counters cleared, dac_out=idle value (current cfg_idle_value), burst_active=0.
  - No burst_done pulse; burst_count holds its value.
- reset asserted mid-burst: next cycle matches the reset values exactly.
- L=1 is legal: one sample per burst.
- Maximum L, P, N = 2^CNT_WIDTH-1. Counters must not overflow at these values.
- Channels are gated identically and simultaneously; no per-channel skew.

Test Plan:
- Reset: hold reset 5 cycles with trigger_in=1 and dac_data ramping, then release with trigger_in still high -> dac_out=0 during reset, no burst after release, burst_active=0.
- Single burst: L=4, P=10, N=1, idle=0x2000, ramp input; rising edge at cycle t -> dac_out = ramp(t..t+3) at t+1..t+4; 0x2000 from t+5; burst_done high only at t+5; burst_count=1.
- Repeat with gap: L=3, P=8, N=3 -> bursts start at t, t+8, t+16; burst_done at t+20; burst_count steps 1,2,3; a second trigger edge at t+5 is ignored.
- Back-to-back and infinite: L=5, P=2, N=0 -> P'=5, burst_active continuously high after start; drop cfg_enable at t+23 -> idle output at t+24, no burst_done, burst_count=4.
- Continuous and config latching: L=0, enable=1 -> 1-cycle pass-through regardless of trigger. Set L=4 and trigger, then change L to 9 mid-burst -> burst still 4 samples.
- Multi-channel: CHANNELS=4, distinct ramps per channel, L=2, N=1 -> all four lanes gated on identical cycles, idle value on every lane.
